// File: rtl/bcd_field_editor_pkg.sv
// Shared definitions for the BCD field editor: button FSM encodings, step direction and BCD constants.
package bcd_field_editor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM_UP = 2'd1,
        ST_ARM_DN = 2'd2,
        ST_BLOCK  = 2'd3
    } state_t;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_t;

    localparam logic [7:0] BCD_ZERO     = 8'h00;
    localparam logic [3:0] BCD_ONES_MAX = 4'h9;

endpackage

// File: rtl/bcd_field_editor_if.sv
// Button/value bus between the debounced button logic (master) and the field editor (slave).
interface bcd_field_editor_if #(
    parameter int NUM_FIELDS = 3,
    parameter int SEL_W      = 2
);
    logic                    edit_en;
    logic                    btn_up;
    logic                    btn_down;
    logic [SEL_W-1:0]        field_sel;
    logic [8*NUM_FIELDS-1:0] load_val;
    logic [8*NUM_FIELDS-1:0] val_out;
    logic                    step_pulse;

    modport master (
        output edit_en, btn_up, btn_down, field_sel, load_val,
        input  val_out, step_pulse
    );

    modport slave (
        input  edit_en, btn_up, btn_down, field_sel, load_val,
        output val_out, step_pulse
    );
endinterface

// File: rtl/bcd_field_editor_step.sv
// Combinational BCD step unit: next value of one 2-digit BCD field for an up/down step with wrap at max.
module bcd_field_editor_step
    import bcd_field_editor_pkg::*;
(
    input  logic [7:0] value,
    input  logic [7:0] max,
    input  dir_t       dir,
    output logic [7:0] next_value
);

    always_comb begin
        next_value = value;
        if (dir == DIR_UP) begin
            // Anything at or above the limit (including a bad load) wraps to zero.
            if (value >= max)
                next_value = BCD_ZERO;
            else if (value[3:0] == BCD_ONES_MAX)
                next_value = {value[7:4] + 4'd1, 4'd0};
            else
                next_value = {value[7:4], value[3:0] + 4'd1};
        end else begin
            if ((value > max) || (value == BCD_ZERO))
                next_value = max;
            else if (value[3:0] == 4'd0)
                next_value = {value[7:4] - 4'd1, BCD_ONES_MAX};
            else
                next_value = {value[7:4], value[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/bcd_field_editor.sv
// Edits NUM_FIELDS packed BCD fields with release-triggered up/down buttons; tracks load_val when idle.
// Optional hold-to-repeat stepping is enabled by defining AUTOREPEAT_EN.
module bcd_field_editor
    import bcd_field_editor_pkg::*;
#(
    parameter int                      NUM_FIELDS   = 3,
    parameter int                      SEL_W        = 2,
    parameter logic [8*NUM_FIELDS-1:0] FIELD_MAX    = {8'h23, 8'h59, 8'h59},
    parameter int                      REPEAT_DELAY = 50_000_000,
    parameter int                      REPEAT_RATE  = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    bcd_field_editor_if.slave  bus
);

    localparam int            SEL_SLOTS = 1 << SEL_W;
    localparam int            VAL_W     = 8 * NUM_FIELDS;
    localparam logic [SEL_W:0] NUM_FIELDS_CMP = (SEL_W + 1)'(NUM_FIELDS);

    if ((NUM_FIELDS > SEL_SLOTS) || (REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_cfg
        $error("bcd_field_editor: invalid parameter set");
    end

    state_t            state_reg, state_next;
    logic [VAL_W-1:0]  val_reg, val_next;
    logic              pulse_reg, pulse_next;

    logic [7:0]        field_cur [SEL_SLOTS];
    logic [7:0]        field_max [SEL_SLOTS];
    logic [7:0]        sel_value, sel_max, step_value;
    logic [VAL_W-1:0]  val_stepped;
    dir_t              step_dir;
    logic              step_req, step_fire, sel_valid;
    logic              repeat_tick, release_ok;

    // Slots past NUM_FIELDS read as zero; sel_valid keeps them from ever being written.
    for (genvar gi = 0; gi < SEL_SLOTS; gi++) begin : g_field_mux
        if (gi < NUM_FIELDS) begin : g_real
            assign field_cur[gi] = val_reg[8*gi +: 8];
            assign field_max[gi] = FIELD_MAX[8*gi +: 8];
        end else begin : g_pad
            assign field_cur[gi] = BCD_ZERO;
            assign field_max[gi] = BCD_ZERO;
        end
    end

    assign sel_valid = ({1'b0, bus.field_sel} < NUM_FIELDS_CMP);
    assign sel_value = field_cur[bus.field_sel];
    assign sel_max   = field_max[bus.field_sel];
    assign step_fire = step_req && sel_valid;

    bcd_field_editor_step u_bcd_step (
        .value      (sel_value),
        .max        (sel_max),
        .dir        (step_dir),
        .next_value (step_value)
    );

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field_demux
        assign val_stepped[8*gi +: 8] = (step_fire && (bus.field_sel == SEL_W'(gi)))
                                        ? step_value : val_reg[8*gi +: 8];
    end

`ifdef AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              repeated_reg, repeated_next;
    logic              hold_active;

    assign hold_active = bus.edit_en &&
                         (((state_reg == ST_ARM_UP) && bus.btn_up && !bus.btn_down) ||
                          ((state_reg == ST_ARM_DN) && bus.btn_down && !bus.btn_up));
    assign repeat_tick = hold_active &&
                         (repeated_reg ? (hold_cnt_reg == HOLD_W'(REPEAT_RATE - 1))
                                       : (hold_cnt_reg == HOLD_W'(REPEAT_DELAY - 1)));
    // Once a repeat has fired, the release belongs to that hold and adds no step.
    assign release_ok  = !repeated_reg;

    always_comb begin
        hold_cnt_next = '0;
        repeated_next = 1'b0;
        if (hold_active) begin
            repeated_next = repeated_reg;
            if (repeat_tick) begin
                hold_cnt_next = '0;
                repeated_next = 1'b1;
            end else begin
                hold_cnt_next = hold_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_reg <= '0;
            repeated_reg <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            repeated_reg <= repeated_next;
        end
    end
`else
    assign repeat_tick = 1'b0;
    assign release_ok  = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        step_req   = 1'b0;
        step_dir   = DIR_UP;
        if (!bus.edit_en) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.btn_up && !bus.btn_down)
                        state_next = ST_ARM_UP;
                    else if (bus.btn_down && !bus.btn_up)
                        state_next = ST_ARM_DN;
                    else if (bus.btn_up && bus.btn_down)
                        state_next = ST_BLOCK;
                end
                ST_ARM_UP: begin
                    step_dir = DIR_UP;
                    if (bus.btn_down) begin
                        state_next = ST_BLOCK;
                    end else if (!bus.btn_up) begin
                        state_next = ST_IDLE;
                        step_req   = release_ok;
                    end else begin
                        step_req   = repeat_tick;
                    end
                end
                ST_ARM_DN: begin
                    step_dir = DIR_DN;
                    if (bus.btn_up) begin
                        state_next = ST_BLOCK;
                    end else if (!bus.btn_down) begin
                        state_next = ST_IDLE;
                        step_req   = release_ok;
                    end else begin
                        step_req   = repeat_tick;
                    end
                end
                ST_BLOCK: begin
                    if (!bus.btn_up && !bus.btn_down)
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        val_next   = val_reg;
        pulse_next = 1'b0;
        if (!bus.edit_en) begin
            val_next = bus.load_val;
        end else if (step_fire) begin
            val_next   = val_stepped;
            pulse_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            val_reg   <= '0;
            pulse_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            val_reg   <= val_next;
            pulse_reg <= pulse_next;
        end
    end

    assign bus.val_out    = val_reg;
    assign bus.step_pulse = pulse_reg;

endmodule
